// File: rtl/mac_checker_pkg.sv
// Shared types and helpers for the benchmark output checkers.
package mac_checker_pkg;

    localparam logic [1:0] IDLE_ENC  = 2'b00;
    localparam logic [1:0] SKIP_ENC  = 2'b01;
    localparam logic [1:0] CHECK_ENC = 2'b10;
    localparam logic [1:0] DONE_ENC  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = IDLE_ENC,
        SKIP  = SKIP_ENC,
        CHECK = CHECK_ENC,
        DONE  = DONE_ENC
    } state_t;

    // Adds inc to count, clamping at 2^width-1 (width up to 32).
    function automatic logic [31:0] sat_add(input logic [31:0] count,
                                            input logic [31:0] inc,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max_v;
        sum   = {1'b0, count} + {1'b0, inc};
        max_v = (33'd1 << width) - 33'd1;
        if (sum > max_v)
            return max_v[31:0];
        return sum[31:0];
    endfunction

endpackage

// File: rtl/mac_output_checker_popcount.sv
// Combinational population count of a mismatch vector.
module mismatch_popcount #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]               bits,
    output logic [$clog2(WIDTH+1)-1:0]     count
);
    localparam int CW = $clog2(WIDTH + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++)
            count = count + CW'(bits[i]);
    end

endmodule

// File: rtl/mac_output_checker.sv
// Compares fabric outputs against reference outputs over a run of samples
// and reports per-bit mismatches, an edge-counted error total and pass/fail.
//
// state | meaning
// IDLE  | waiting for start, outputs at reset values
// SKIP  | one initialisation sample discarded, no compare
// CHECK | comparing one sample per cycle, NUM_SAMPLES in total
// DONE  | results held until the next start
module mac_output_checker
    import mac_checker_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int NUM_SAMPLES = 10,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dut_out,
    input  logic [WIDTH-1:0] ref_out,
    input  logic [WIDTH-1:0] ref_valid,
    output logic [WIDTH-1:0] mismatch_flag,
    output logic [CNT_W-1:0] error_count,
    output logic             busy,
    output logic             done,
    output logic             pass
);
    localparam int SMP_W = $clog2(NUM_SAMPLES + 1);
    localparam int POP_W = $clog2(WIDTH + 1);

    if (NUM_SAMPLES < 1) begin : g_bad_num_samples
        $error("mac_output_checker: NUM_SAMPLES must be at least 1");
    end
    if (CNT_W > 32) begin : g_bad_cnt_w
        $error("mac_output_checker: CNT_W must not exceed 32");
    end

    state_t             state;
    logic [SMP_W-1:0]   smp_left;
    logic [WIDTH-1:0]   raw;
    logic [WIDTH-1:0]   new_bits;
    logic [POP_W-1:0]   new_cnt;

    // Unknown reference bits are masked; only CHECK produces mismatches.
    assign raw      = (state == CHECK) ? (ref_valid & (dut_out ^ ref_out)) : '0;
    assign new_bits = raw & ~mismatch_flag;

    mismatch_popcount #(.WIDTH(WIDTH)) u_popcount (
        .bits  (new_bits),
        .count (new_cnt)
    );

    assign pass = done & (error_count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            smp_left      <= '0;
            mismatch_flag <= '0;
            error_count   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            mismatch_flag <= raw;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= SKIP;
                        smp_left    <= '0;
                        error_count <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                SKIP: begin
                    state    <= CHECK;
                    smp_left <= SMP_W'(NUM_SAMPLES - 1);
                end
                CHECK: begin
                    error_count <= CNT_W'(sat_add(32'(error_count), 32'(new_cnt), CNT_W));
                    // Terminal count: this edge takes the last sample's events too.
                    if (smp_left == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        smp_left <= smp_left - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_output_checker.sv
// Directed bench with a done-triggered scoreboard for two checker instances.
module tb_mac_output_checker;

    localparam int W  = 4;
    localparam int NS = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dut_out, ref_out, ref_valid;

    logic [W-1:0] flag_a, flag_s;
    logic [15:0]  error_count_a;
    logic [1:0]   error_count_s;
    logic         busy_a, done_a, pass_a;
    logic         busy_s, done_s, pass_s;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int cnt_a;
        int cnt_s;
    } exp_t;
    exp_t sb_q[$];

    logic [W-1:0] sd[0:NS];
    logic [W-1:0] sr[0:NS];
    logic [W-1:0] sv[0:NS];
    logic [W-1:0] ef[0:NS];

    always #5 clk = ~clk;

    mac_output_checker #(.WIDTH(W), .NUM_SAMPLES(NS), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .start(start),
        .dut_out(dut_out), .ref_out(ref_out), .ref_valid(ref_valid),
        .mismatch_flag(flag_a), .error_count(error_count_a),
        .busy(busy_a), .done(done_a), .pass(pass_a)
    );

    mac_output_checker #(.WIDTH(W), .NUM_SAMPLES(NS), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .start(start),
        .dut_out(dut_out), .ref_out(ref_out), .ref_valid(ref_valid),
        .mismatch_flag(flag_s), .error_count(error_count_s),
        .busy(busy_s), .done(done_s), .pass(pass_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation on every rising done.
    logic done_q = 1'b0;
    always @(negedge clk) begin
        if (done_a && !done_q) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("error_count_a", 32'(error_count_a), e.cnt_a);
                chk("pass_a", 32'(pass_a), 32'(e.cnt_a == 0));
                chk("done_s", 32'(done_s), 32'd1);
                chk("error_count_s", 32'(error_count_s), e.cnt_s);
                chk("pass_s", 32'(pass_s), 32'(e.cnt_s == 0));
                chk("busy_at_done", 32'(busy_a), 32'd0);
            end
        end
        done_q <= done_a;
    end

    task automatic fill(input logic [W-1:0] d, input logic [W-1:0] r, input logic [W-1:0] v);
        for (int k = 0; k <= NS; k++) begin
            sd[k] = d; sr[k] = r; sv[k] = v; ef[k] = '0;
        end
    endtask

    task automatic idle_inputs();
        dut_out = '0; ref_out = '0; ref_valid = '0;
    endtask

    task automatic issue_run(input int exp_a, input int exp_s);
        exp_t e;
        e.cnt_a = exp_a;
        e.cnt_s = exp_s;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("count_cleared_on_start", 32'(error_count_a), 32'd0);
        chk("busy_after_start", 32'(busy_a), 32'd1);
        chk("done_low_after_start", 32'(done_a), 32'd0);
        dut_out = sd[0]; ref_out = sr[0]; ref_valid = sv[0];
        for (int k = 1; k <= NS; k++) begin
            @(negedge clk);
            chk($sformatf("flag_sample%0d", k - 1), 32'(flag_a), 32'(ef[k-1]));
            chk($sformatf("done_early_%0d", k), 32'(done_a), 32'd0);
            dut_out = sd[k]; ref_out = sr[k]; ref_valid = sv[k];
        end
        @(negedge clk);
        chk("done_after_11", 32'(done_a), 32'd1);
        chk("flag_sample10", 32'(flag_a), 32'(ef[NS]));
        idle_inputs();
        @(negedge clk);
        chk("flag_zero_in_done", 32'(flag_a), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("reset_flag", 32'(flag_a), 32'd0);
        chk("reset_count", 32'(error_count_a), 32'd0);
        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_done", 32'(done_a), 32'd0);
        chk("reset_pass", 32'(pass_a), 32'd0);
        reset = 1'b0;

        // Clean run
        fill(4'hA, 4'hA, 4'hF);
        issue_run(0, 0);

        // Mismatch only in the skip sample
        fill(4'h3, 4'h3, 4'hF);
        sd[0] = 4'h1; sr[0] = 4'h0;
        issue_run(0, 0);

        // Edge counting: bit0 on samples 2-4 and 7, bit3 on sample 7
        fill(4'h5, 4'h5, 4'hF);
        for (int k = 2; k <= 4; k++) begin
            sd[k] = 4'h4; ef[k] = 4'h1;
        end
        sd[7] = 4'hC; ef[7] = 4'h9;
        issue_run(3, 3);

        // Unknown mask hides every difference
        fill(4'hF, 4'h0, 4'h0);
        issue_run(0, 0);

        // All bits mismatch on odd samples: 5 x 4 events, narrow counter clamps
        fill(4'h6, 4'h6, 4'hF);
        for (int k = 1; k <= NS; k += 2) begin
            sd[k] = 4'h9; ef[k] = 4'hF;
        end
        issue_run(20, 3);

        // Two events including one on the last sample
        fill(4'h0, 4'h0, 4'hF);
        sd[1]  = 4'h4; ef[1]  = 4'h4;
        sd[NS] = 4'h4; ef[NS] = 4'h4;
        issue_run(2, 2);

        // Restart from DONE with error_count=2 pending
        fill(4'h7, 4'h7, 4'hF);
        issue_run(0, 0);

        // Mid-run reset with start asserted in the same cycle
        fill(4'h3, 4'h3, 4'hF);
        sd[2] = 4'h1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dut_out = sd[0]; ref_out = sr[0]; ref_valid = sv[0];
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            dut_out = sd[k]; ref_out = sr[k]; ref_valid = sv[k];
        end
        @(negedge clk);
        chk("pending_count_before_reset", 32'(error_count_a), 32'd1);
        chk("busy_before_reset", 32'(busy_a), 32'd1);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("midreset_count", 32'(error_count_a), 32'd0);
        chk("midreset_flag", 32'(flag_a), 32'd0);
        chk("midreset_busy", 32'(busy_a), 32'd0);
        chk("midreset_done", 32'(done_a), 32'd0);
        chk("midreset_pass", 32'(pass_a), 32'd0);
        reset = 1'b0; start = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        chk("idle_after_reset_busy", 32'(busy_a), 32'd0);
        chk("idle_after_reset_done", 32'(done_a), 32'd0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
